keypoint_nms_3x3: RTL

- Streaming 3x3 non-maximum-suppression stage; sits directly downstream of the 5x5 smoothing window.
- Consumes its dout, blanking_out and validout stream.
- Keeps two line buffers plus a 3x3 register window and flags the window centre as a keypoint when it is a strict local maximum above a programmable threshold.
- Passes the centre pixel and its delayed blanking flag through, so the next stage sees an aligned pixel/flag stream.

---
 rtl/keypoint_nms_3x3.sv | 114 +++++++++++
 1 files changed

// File: rtl/keypoint_nms_3x3.sv
// Streaming 3x3 non-maximum suppression stage. It flags the window centre as a keypoint
// when the centre is a strict local maximum at or above threshold. It also forwards the
// centre pixel and its blanking flag.
module keypoint_nms_3x3 #(
  parameter int unsigned width = 420,
  parameter int unsigned cnt_w = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       blanking_in,
  input  logic       validin,
  input  logic [7:0] threshold,
  output logic [7:0] dout,
  output logic       keypoint,
  output logic       blanking_out,
  output logic       validout
);

  localparam int unsigned       FILL_W      = cnt_w + 2;
  localparam logic [cnt_w-1:0]  COL_LAST    = cnt_w'(width - 1);
  localparam logic [FILL_W-1:0] FILL_CENTRE = FILL_W'(width + 1);
  localparam logic [FILL_W-1:0] FILL_WARM   = FILL_W'(2 * width + 2);
  localparam logic [8:0]        EMPTY       = 9'h100;

  logic [8:0]        lb0 [width];
  logic [8:0]        lb1 [width];
  logic [8:0]        win [3][3];
  logic [8:0]        nxt [3][3];
  logic [8:0]        in_word;
  logic [8:0]        lb0_rd;
  logic [8:0]        lb1_rd;
  logic [cnt_w-1:0]  in_col;
  logic [cnt_w-1:0]  c_col;
  logic [FILL_W-1:0] fill;
  logic              warm;
  logic              any_blank;
  logic              all_less;
  logic              kp_c;

  assign in_word = {blanking_in, din};
  assign lb0_rd  = lb0[in_col];
  assign lb1_rd  = lb1[in_col];
  assign warm    = (fill == FILL_WARM);

  // Line buffers: read-before-write at in_col gives exactly one row of delay each
  always_ff @(posedge clock) begin
    if (validin) begin
      lb0[in_col] <= in_word;
      lb1[in_col] <= lb0_rd;
    end
  end

  // Window as it will be after this sample, plus the keypoint decision on it
  always_comb begin
    nxt[0][0] = in_word;
    nxt[1][0] = lb0_rd;
    nxt[2][0] = lb1_rd;
    for (int r = 0; r < 3; r++) begin
      nxt[r][1] = win[r][0];
      nxt[r][2] = win[r][1];
    end
    any_blank = 1'b0;
    all_less  = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        any_blank = any_blank | nxt[r][c][8];
        if ((r != 1 || c != 1) && (nxt[r][c][7:0] >= nxt[1][1][7:0])) begin
          all_less = 1'b0;
        end
      end
    end
    kp_c = warm && (c_col != '0) && (c_col != COL_LAST) && !any_blank &&
           (nxt[1][1][7:0] >= threshold) && all_less;
  end

  // Counters, window and registered outputs; c_col names the column of the incoming centre
  always_ff @(posedge clock) begin
    if (reset) begin
      in_col       <= '0;
      c_col        <= '0;
      fill         <= '0;
      validout     <= 1'b0;
      dout         <= '0;
      keypoint     <= 1'b0;
      blanking_out <= 1'b1;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= EMPTY;
        end
      end
    end else begin
      validout <= validin;
      if (validin) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            win[r][c] <= nxt[r][c];
          end
        end
        in_col <= (in_col == COL_LAST) ? '0 : in_col + cnt_w'(1);
        if (!warm) begin
          fill <= fill + FILL_W'(1);
        end
        if (fill >= FILL_CENTRE) begin
          c_col <= (c_col == COL_LAST) ? '0 : c_col + cnt_w'(1);
        end
        dout         <= nxt[1][1][7:0];
        blanking_out <= nxt[1][1][8] | ~warm;
        keypoint     <= kp_c;
      end
    end
  end

endmodule
